controle_rega: RTL and testbench

Irrigation control state machine that sits directly downstream of the system timer and consumes its one-cycle tick pulses. It reads soil-moisture, tank-level and temperature sensors. It then drives the sprinkler, drip and tank-fill valves through timed irrigation cycles with a mandatory rest period. It also raises an alarm on sensor fault and counts completed irrigation cycles.

---
 rtl/controle_rega.sv | 183 ++++++++++++++++++
 tb/tb_controle_rega.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_rega.sv
// -----------------------------------------------------------------------------
// controle_rega
// Irrigation sequencer. It is driven by the system timer's one-cycle tick
// pulses and runs timed sprinkler or drip cycles, refills the tank, enforces a
// rest period after each run, and raises an alarm while the moisture sensor
// reports a fault. It also counts completed irrigation runs, saturating at 255.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE     (0) | waiting for dry soil
// ASPERSAO (1) | sprinkler valve open, timed by T_ASP minutes
// GOTEJAMENTO(2)| drip valve open, timed by T_GOT minutes
// PAUSA    (3) | mandatory rest, T_PAUSA minutes
// ENCHE    (4) | tank fill valve open until level is no longer low
// ALARME   (5) | sensor fault; two clean tick_dseg samples are needed to leave
// 6, 7         | illegal; forced back to IDLE on the next clock
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   tick_dseg     in   1-cycle pulse every 10 s
//   tick_min      in   1-cycle pulse every minute
//   umidade[1:0]  in   00 dry, 01 medium, 10 wet, 11 sensor fault
//   nivel_baixo   in   tank level low
//   temp_alta     in   high ambient temperature
//   valvula_asp   out  sprinkler valve
//   valvula_got   out  drip valve
//   valvula_enche out  tank fill valve
//   alarme        out  sensor fault alarm
//   estado[2:0]   out  current state code
//   ciclos[7:0]   out  completed irrigation runs, saturating
// -----------------------------------------------------------------------------
module controle_rega #(
  parameter int T_ASP   = 3,
  parameter int T_GOT   = 5,
  parameter int T_PAUSA = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_dseg,
  input  logic       tick_min,
  input  logic [1:0] umidade,
  input  logic       nivel_baixo,
  input  logic       temp_alta,
  output logic       valvula_asp,
  output logic       valvula_got,
  output logic       valvula_enche,
  output logic       alarme,
  output logic [2:0] estado,
  output logic [7:0] ciclos
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ASP    = 3'd1,
    S_GOT    = 3'd2,
    S_PAUSA  = 3'd3,
    S_ENCHE  = 3'd4,
    S_ALARME = 3'd5,
    S_ILL6   = 3'd6,
    S_ILL7   = 3'd7
  } state_t;

  // Terminal counts: the run ends on the tick_min that arrives while the
  // counter already holds T-1.
  localparam logic [3:0] LP_ASP_LAST   = 4'(T_ASP - 1);
  localparam logic [3:0] LP_GOT_LAST   = 4'(T_GOT - 1);
  localparam logic [3:0] LP_PAUSA_LAST = 4'(T_PAUSA - 1);

  localparam logic [1:0] LP_UM_SECO  = 2'b00;
  localparam logic [1:0] LP_UM_UMIDO = 2'b10;
  localparam logic [1:0] LP_UM_FALHA = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_min_cnt;
  logic [1:0] r_conf_cnt;
  logic [1:0] w_conf_next;
  logic [7:0] r_ciclos;
  logic       w_cycle_done;
  logic       w_changing;
  logic       w_timed;

  always_comb begin
    w_next      = r_state;
    w_conf_next = r_conf_cnt;

    if (r_state == S_ILL6 || r_state == S_ILL7) begin
      w_next = S_IDLE;
    end else if (r_state == S_ALARME) begin
      // A faulty sample restarts the confirmation; the second clean sample exits.
      if (tick_dseg) begin
        if (umidade == LP_UM_FALHA) begin
          w_conf_next = 2'd0;
        end else if (r_conf_cnt == 2'd1) begin
          w_next = S_IDLE;
        end else begin
          w_conf_next = r_conf_cnt + 2'd1;
        end
      end
    end else if (umidade == LP_UM_FALHA) begin
      w_next = S_ALARME;
    end else if (nivel_baixo &&
                 (r_state == S_IDLE || r_state == S_ASP || r_state == S_GOT)) begin
      w_next = S_ENCHE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (umidade == LP_UM_SECO) begin
            w_next = temp_alta ? S_GOT : S_ASP;
          end
        end
        S_ASP: begin
          if (umidade == LP_UM_UMIDO) begin
            w_next = S_PAUSA;
          end else if (tick_min && r_min_cnt == LP_ASP_LAST) begin
            w_next = S_PAUSA;
          end
        end
        S_GOT: begin
          if (umidade == LP_UM_UMIDO) begin
            w_next = S_PAUSA;
          end else if (tick_min && r_min_cnt == LP_GOT_LAST) begin
            w_next = S_PAUSA;
          end
        end
        S_PAUSA: begin
          if (tick_min && r_min_cnt == LP_PAUSA_LAST) begin
            w_next = S_IDLE;
          end
        end
        S_ENCHE: begin
          if (tick_dseg && !nivel_baixo) begin
            w_next = S_PAUSA;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_changing   = (w_next != r_state);
  assign w_timed      = (r_state == S_ASP) || (r_state == S_GOT) || (r_state == S_PAUSA);
  // Only a run ending in PAUSA counts; exits to ENCHE or ALARME do not.
  assign w_cycle_done = ((r_state == S_ASP) || (r_state == S_GOT)) && (w_next == S_PAUSA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_min_cnt  <= 4'd0;
      r_conf_cnt <= 2'd0;
      r_ciclos   <= 8'd0;
    end else begin
      r_state <= w_next;

      // A tick_min on the entry edge is swallowed by the clear.
      if (w_changing) begin
        r_min_cnt <= 4'd0;
      end else if (tick_min && w_timed) begin
        r_min_cnt <= r_min_cnt + 4'd1;
      end

      if (w_changing) begin
        r_conf_cnt <= 2'd0;
      end else begin
        r_conf_cnt <= w_conf_next;
      end

      if (w_cycle_done && r_ciclos != 8'hFF) begin
        r_ciclos <= r_ciclos + 8'd1;
      end
    end
  end

  // Moore decode straight off the state register so reset closes valves at once.
  assign valvula_asp   = (r_state == S_ASP);
  assign valvula_got   = (r_state == S_GOT);
  assign valvula_enche = (r_state == S_ENCHE);
  assign alarme        = (r_state == S_ALARME);
  assign estado        = r_state;
  assign ciclos        = r_ciclos;

endmodule

// File: tb/tb_controle_rega.sv
module tb_controle_rega;

  localparam int T_ASP   = 3;
  localparam int T_GOT   = 5;
  localparam int T_PAUSA = 2;

  logic       clock;
  logic       reset;
  logic       tick_dseg;
  logic       tick_min;
  logic [1:0] umidade;
  logic       nivel_baixo;
  logic       temp_alta;
  logic       valvula_asp;
  logic       valvula_got;
  logic       valvula_enche;
  logic       alarme;
  logic [2:0] estado;
  logic [7:0] ciclos;

  controle_rega #(.T_ASP(T_ASP), .T_GOT(T_GOT), .T_PAUSA(T_PAUSA)) dut (
    .clock(clock), .reset(reset), .tick_dseg(tick_dseg), .tick_min(tick_min),
    .umidade(umidade), .nivel_baixo(nivel_baixo), .temp_alta(temp_alta),
    .valvula_asp(valvula_asp), .valvula_got(valvula_got),
    .valvula_enche(valvula_enche), .alarme(alarme),
    .estado(estado), .ciclos(ciclos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] estado;
    logic       asp;
    logic       got;
    logic       enche;
    logic       alarme;
    logic [7:0] ciclos;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec;
  int   n_bad;

  // Reference model: state as a plain integer, minutes elapsed in the current
  // run, clean alarm confirmations seen, completed runs.
  int m_state;
  int m_mins;
  int m_ok;
  int m_cyc;

  function automatic obs_t model_out();
    obs_t o;
    o.estado = 3'(m_state);
    o.asp    = (m_state == 1);
    o.got    = (m_state == 2);
    o.enche  = (m_state == 4);
    o.alarme = (m_state == 5);
    o.ciclos = 8'(m_cyc);
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_mins = 0; m_ok = 0; m_cyc = 0;
  endtask

  task automatic model_step(input int um, input bit nb, input bit ta,
                            input bit td, input bit tm);
    int ns;
    int limit;
    ns = m_state;
    if (m_state == 5) begin
      if (td) begin
        if (um == 3) m_ok = 0;
        else begin
          m_ok = m_ok + 1;
          if (m_ok >= 2) ns = 0;
        end
      end
    end else if (um == 3) begin
      ns = 5;
    end else if (nb && m_state <= 2) begin
      ns = 4;
    end else if (m_state == 0) begin
      if (um == 0) ns = ta ? 2 : 1;
    end else if (m_state == 1 || m_state == 2) begin
      limit = (m_state == 1) ? T_ASP : T_GOT;
      if (um == 2) ns = 3;
      else if (tm && m_mins + 1 >= limit) ns = 3;
    end else if (m_state == 3) begin
      if (tm && m_mins + 1 >= T_PAUSA) ns = 0;
    end else if (m_state == 4) begin
      if (td && !nb) ns = 3;
    end
    if (ns != m_state) begin
      if ((m_state == 1 || m_state == 2) && ns == 3 && m_cyc < 255) m_cyc++;
      m_mins = 0;
      m_ok   = 0;
    end else if (tm) begin
      m_mins++;
    end
    m_state = ns;
  endtask

  function automatic obs_t dut_out();
    obs_t o;
    o.estado = estado;
    o.asp    = valvula_asp;
    o.got    = valvula_got;
    o.enche  = valvula_enche;
    o.alarme = alarme;
    o.ciclos = ciclos;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t g;
    g = dut_out();
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: got estado=%0d asp=%b got=%b enche=%b alarme=%b ciclos=%0d, want estado=%0d asp=%b got=%b enche=%b alarme=%b ciclos=%0d",
               name, $time, g.estado, g.asp, g.got, g.enche, g.alarme, g.ciclos,
               e.estado, e.asp, e.got, e.enche, e.alarme, e.ciclos);
    end
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cycle", e);
      end
    end
  end

  task automatic step(input logic [1:0] um, input bit nb, input bit ta,
                      input bit td, input bit tm);
    @(negedge clock);
    umidade = um; nivel_baixo = nb; temp_alta = ta; tick_dseg = td; tick_min = tm;
    if (reset) model_reset();
    else model_step(int'(um), nb, ta, td, tm);
    exp_q.push_back(model_out());
    @(posedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // n quiet cycles then one tick_min, with sensors held
  task automatic minute(input logic [1:0] um, input bit nb, input bit ta, input int n);
    for (int i = 0; i < n; i++) step(um, nb, ta, 1'b0, 1'b0);
    step(um, nb, ta, 1'b0, 1'b1);
  endtask

  logic [1:0] r_um;
  bit         r_nb;
  bit         r_ta;

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1;
    tick_dseg = 1'b0; tick_min = 1'b0; umidade = 2'b01;
    nivel_baixo = 1'b0; temp_alta = 1'b0;
    model_reset();
    #1;
    check("reset_state", model_out());
    step(2'b01, 0, 0, 0, 0);
    release_reset();

    // Sprinkler run: 3 minutes then rest of 2 minutes.
    step(2'b00, 0, 0, 0, 1);
    for (int k = 0; k < T_ASP; k++) minute(2'b01, 0, 0, 2);
    for (int k = 0; k < T_PAUSA; k++) minute(2'b01, 0, 0, 1);
    step(2'b01, 0, 0, 1, 0);

    // Drip run cut short by wet soil after two minutes.
    step(2'b00, 0, 1, 0, 0);
    minute(2'b01, 0, 1, 1);
    minute(2'b01, 0, 1, 1);
    step(2'b10, 0, 1, 0, 0);
    for (int k = 0; k < T_PAUSA; k++) minute(2'b10, 0, 0, 0);

    // Low tank during a sprinkler run, then refill, then rest.
    step(2'b00, 0, 0, 0, 0);
    minute(2'b01, 0, 0, 1);
    step(2'b01, 1, 0, 0, 0);
    step(2'b01, 1, 0, 1, 1);
    step(2'b01, 0, 0, 0, 0);
    step(2'b01, 0, 0, 1, 1);

    // Fault during rest, a faulty confirmation sample, then two clean ones.
    step(2'b11, 0, 0, 0, 0);
    step(2'b01, 0, 0, 1, 0);
    step(2'b11, 0, 0, 1, 0);
    step(2'b01, 0, 0, 1, 0);
    step(2'b01, 0, 0, 0, 0);
    step(2'b01, 0, 0, 1, 1);

    // Expiry coinciding with wet soil: one transition, one increment.
    step(2'b00, 0, 0, 0, 0);
    minute(2'b01, 0, 0, 0);
    minute(2'b01, 0, 0, 0);
    step(2'b10, 0, 0, 1, 1);
    minute(2'b01, 0, 0, 0);
    minute(2'b01, 0, 0, 0);
    // Expiry coinciding with a fault: ALARME, no increment.
    step(2'b00, 0, 0, 0, 0);
    minute(2'b01, 0, 0, 0);
    minute(2'b01, 0, 0, 0);
    step(2'b11, 0, 0, 0, 1);
    step(2'b01, 0, 0, 1, 0);
    step(2'b01, 0, 0, 1, 0);

    // Randomized traffic with slowly changing sensors.
    r_um = 2'b01; r_nb = 0; r_ta = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)
        r_um = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) r_nb = ~r_nb;
      if ($urandom_range(0, 7) == 0)  r_ta = ~r_ta;
      step(r_um, r_nb, r_ta, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    // Drain any condition back to IDLE with clean sensors.
    for (int i = 0; i < 40; i++) step(2'b01, 0, 0, 1, 1);

    // Saturate the run counter.
    for (int i = 0; i < 260; i++) begin
      step(2'b00, 0, 0, 0, 1);
      step(2'b10, 0, 0, 0, 1);
      step(2'b10, 0, 0, 0, 1);
      step(2'b10, 0, 0, 0, 1);
    end

    // Asynchronous reset in the middle of a sprinkler run.
    step(2'b00, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", model_out());
    step(2'b00, 0, 0, 0, 0);
    release_reset();
    step(2'b00, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);

    @(posedge clock);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
